execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
// - EX stage of the 5-stage MIPS32 pipeline: holds the ID/EX pipeline register, ALU, branch-target adder, iterative HI/LO mul/div unit.
// - Consumes decode-stage controls/operands; produces the *_e bundle that the Memory stage registers into EX/MEM.
// - Stalls fetch/decode via md_busy while a multi-cycle mul/div occupies EX.
// PARAMETERS
// - DIV0_LO  32'hFFFF_FFFF  LO value written on divide-by-zero (HI gets dividend rs)
// PORTS
// - clk          in   1   clock, all state on posedge
// - rst          in   1   synchronous, active-high reset
// - reg_write_d, mem_to_reg_d, mem_write_d, branch_d, alu_src_d, reg_dst_d  in 1 each  decode controls
// - alu_ctrl_d   in   4   ALU op (table below)
// - md_op_d      in   3   0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO
// - j_inst_d     in   2   00 none, 01 J, 10 JAL, 11 JR
// - rd1_d, rd2_d in   32  rs/rt operands
// - sign_imm_d   in   32  sign-extended immediate ([10:6] = shamt)
// - pc_plus4_d, jump_addr_d  in 32  PC+4, pseudo-direct jump target
// - rt_d, rd_d   in   5   destination candidates
// - flush_e      in   1   load bubble into ID/EX (branch taken)
// - reg_write_e, mem_to_reg_e, mem_write_e, branch_e  out 1  controls to Memory
// - alu_out_e, write_data_e, pc_branch_e, jump_addr_e  out 32  results to Memory
// - write_reg_e  out  5   destination register;  zero_e out 1  ALU result == 0
// - j_inst_e     out  2   registered j_inst_d
// - md_busy      out  1   stall request to IF/ID
// BEHAVIOUR
// - ID/EX reg: rst -> all fields 0 (bubble); md_busy -> hold; else flush_e -> bubble; else capture *_d.
// - flush_e ignored while md_busy (upstream is held); rst overrides everything.
// - Combinational outputs from ID/EX: srcB = alu_src ? sign_imm : rd2; write_data_e = rd2; write_reg_e = reg_dst ? rd : rt;
//   pc_branch_e = pc_plus4 + (sign_imm<<2) (mod 2^32); jump_addr_e, j_inst_e pass through; zero_e = (alu_out_e == 0).
// - ALU: 0 AND,1 OR,2 ADD,3 XOR,4 NOR,5 SLTU,6 SUB,7 SLT,8 SLL,9 SRL,A SRA (srcB by shamt),B LUI (imm<<16), C-F -> 0. No overflow traps.
// - md_op MFHI/MFLO: alu_out_e = HI/LO (overrides ALU). Reset of all outputs: 0 (md_busy 0).
// - Mul/div FSM IDLE->RUN->DONE->IDLE:
//   IDLE: ID/EX holds op 1-4 -> md_busy=1, latch |rs|,|rt| + signs, cnt=0, go RUN.
//   RUN: one radix-2 step/cycle (shift-add mult, restoring div), md_busy=1; cnt==31 -> write HI/LO, go DONE.
//   DONE: md_busy=0, ID/EX advances next edge, go IDLE. EX occupancy 34 cycles, md_busy high 33 cycles.
// - While md_busy: reg_write_e, mem_to_reg_e, mem_write_e, branch_e forced 0 (no side effects repeat).
// - Signed: magnitudes, then negate product if signs differ; quotient sign = rs^rt, remainder sign = rs.
// - Div by zero: LO=DIV0_LO, HI=rs, no exception. 0x8000_0000 / -1 (signed): LO=0x8000_0000, HI=0.
// - rst mid-RUN: FSM IDLE, HI=LO=0, md_busy=0 next cycle, ID/EX bubble.
// CONFIGURATION
// - EXECUTE_MULDIV_EN defined: HI/LO regs and FSM as above.
// - Not defined: no HI/LO, md_busy tied 0, md_op 1-4 act as NOP (controls pass through), MFHI/MFLO return 0.
// TESTING
// - ADD ctrl=2, rs=5, rt=7, alu_src=0 -> next cycle alu_out_e=12, zero_e=0, write_reg_e per reg_dst.
// - BEQ SUB rs=rt=9, branch_d=1, pc_plus4=0x100, imm=3 -> zero_e=1, branch_e=1, pc_branch_e=0x10C.
// - MULT 7 x -3 -> md_busy high 33 cycles, then MFHI=0xFFFF_FFFF, MFLO=0xFFFF_FFEB; ID/EX frozen throughout.
// - DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 10/0 -> LO=DIV0_LO, HI=10.
// - rst asserted at RUN cnt=10 -> next cycle md_busy=0, all *_e=0, MFLO=0.
// - flush_e with SW in decode -> mem_write_e=0, reg_write_e=0 next cycle; flush_e during md_busy -> no effect.

Source files
------------

// File: rtl/execute.sv
// EX stage of the 5-stage MIPS32 pipeline: ID/EX register, ALU, branch adder, iterative HI/LO mul/div.
// Define EXECUTE_MULDIV_EN to build the HI/LO registers and the mul/div FSM; otherwise md_busy is tied 0.
module execute #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_d,
    input  logic        mem_to_reg_d,
    input  logic        mem_write_d,
    input  logic        branch_d,
    input  logic        alu_src_d,
    input  logic        reg_dst_d,
    input  logic [3:0]  alu_ctrl_d,
    input  logic [2:0]  md_op_d,
    input  logic [1:0]  j_inst_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [31:0] sign_imm_d,
    input  logic [31:0] pc_plus4_d,
    input  logic [31:0] jump_addr_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rd_d,
    input  logic        flush_e,
    output logic        reg_write_e,
    output logic        mem_to_reg_e,
    output logic        mem_write_e,
    output logic        branch_e,
    output logic [31:0] alu_out_e,
    output logic [31:0] write_data_e,
    output logic [31:0] pc_branch_e,
    output logic [31:0] jump_addr_e,
    output logic [4:0]  write_reg_e,
    output logic        zero_e,
    output logic [1:0]  j_inst_e,
    output logic        md_busy
);
    typedef struct packed {
        logic        reg_write, mem_to_reg, mem_write, branch, alu_src, reg_dst;
        logic [3:0]  alu_ctrl;
        logic [2:0]  md_op;
        logic [1:0]  j_inst;
        logic [31:0] rd1, rd2, sign_imm, pc_plus4, jump_addr;
        logic [4:0]  rt, rd;
    } idex_t;

    idex_t       idex, idex_d;
    logic [31:0] src_b, alu_res, hi_val, lo_val;
    logic [4:0]  shamt;

    assign idex_d = '{reg_write: reg_write_d, mem_to_reg: mem_to_reg_d, mem_write: mem_write_d,
                      branch: branch_d, alu_src: alu_src_d, reg_dst: reg_dst_d,
                      alu_ctrl: alu_ctrl_d, md_op: md_op_d, j_inst: j_inst_d,
                      rd1: rd1_d, rd2: rd2_d, sign_imm: sign_imm_d, pc_plus4: pc_plus4_d,
                      jump_addr: jump_addr_d, rt: rt_d, rd: rd_d};

    // Upstream is frozen while md_busy, so a flush arriving then is ignored too.
    always_ff @(posedge clk) begin
        if (rst)
            idex <= '0;
        else if (!md_busy)
            idex <= flush_e ? '0 : idex_d;
    end

    assign src_b = idex.alu_src ? idex.sign_imm : idex.rd2;
    assign shamt = idex.sign_imm[10:6];

    always_comb begin
        alu_res = '0;
        case (idex.alu_ctrl)
            4'h0: alu_res = idex.rd1 & src_b;
            4'h1: alu_res = idex.rd1 | src_b;
            4'h2: alu_res = idex.rd1 + src_b;
            4'h3: alu_res = idex.rd1 ^ src_b;
            4'h4: alu_res = ~(idex.rd1 | src_b);
            4'h5: alu_res = {31'd0, idex.rd1 < src_b};
            4'h6: alu_res = idex.rd1 - src_b;
            4'h7: alu_res = {31'd0, $signed(idex.rd1) < $signed(src_b)};
            4'h8: alu_res = src_b << shamt;
            4'h9: alu_res = src_b >> shamt;
            4'hA: alu_res = $unsigned($signed(src_b) >>> shamt);
            4'hB: alu_res = {idex.sign_imm[15:0], 16'd0};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (idex.md_op)
            3'd5:    alu_out_e = hi_val;
            3'd6:    alu_out_e = lo_val;
            default: alu_out_e = alu_res;
        endcase
    end

    assign zero_e       = (alu_out_e == 32'd0);
    assign write_data_e = idex.rd2;
    assign write_reg_e  = idex.reg_dst ? idex.rd : idex.rt;
    assign pc_branch_e  = idex.pc_plus4 + (idex.sign_imm << 2);
    assign jump_addr_e  = idex.jump_addr;
    assign j_inst_e     = idex.j_inst;
    assign reg_write_e  = idex.reg_write  & ~md_busy;
    assign mem_to_reg_e = idex.mem_to_reg & ~md_busy;
    assign mem_write_e  = idex.mem_write  & ~md_busy;
    assign branch_e     = idex.branch     & ~md_busy;

`ifdef EXECUTE_MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

    md_state_t   state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, acc_hi, acc_lo, b_mag, a_raw;
    logic        is_div, neg_q, neg_r, b_zero;
    logic        md_start, op_signed, sa, sb;
    logic [31:0] step_hi, step_lo, res_hi, res_lo;
    logic [32:0] mul_sum, div_sh;
    logic [33:0] div_trial;
    logic [63:0] prod_mag, prod;

    assign md_start  = (idex.md_op >= 3'd1) && (idex.md_op <= 3'd4);
    assign op_signed = (idex.md_op == 3'd1) || (idex.md_op == 3'd3);
    assign sa        = op_signed & idex.rd1[31];
    assign sb        = op_signed & idex.rd2[31];
    assign md_busy   = (state == MD_IDLE && md_start) || (state == MD_RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (md_start) state_nxt = MD_RUN;
            MD_RUN:  if (cnt == 5'd31) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One radix-2 step: shift-add multiply in {acc_hi,acc_lo}, or restoring divide with quotient bits into acc_lo.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : 33'd0);
    assign div_sh    = {acc_hi, acc_lo[31]};
    assign div_trial = {1'b0, div_sh} - {2'b0, b_mag};

    always_comb begin
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], acc_lo[31:1]};
        if (is_div) begin
            if (!div_trial[33]) begin
                step_hi = div_trial[31:0];
                step_lo = {acc_lo[30:0], 1'b1};
            end else begin
                step_hi = div_sh[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end
        end
    end

    assign prod_mag = {step_hi, step_lo};
    assign prod     = neg_q ? -prod_mag : prod_mag;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = DIV0_LO;
            end else begin
                res_hi = neg_r ? -step_hi : step_hi;
                res_lo = neg_q ? -step_lo : step_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0; hi <= '0; lo <= '0; acc_hi <= '0; acc_lo <= '0;
            b_mag <= '0; a_raw <= '0; is_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; b_zero <= 1'b0;
        end else if (state == MD_IDLE && md_start) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= sa ? -idex.rd1 : idex.rd1;
            b_mag  <= sb ? -idex.rd2 : idex.rd2;
            a_raw  <= idex.rd1;
            is_div <= idex.md_op >= 3'd3;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= idex.rd2 == 32'd0;
        end else if (state == MD_RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    assign hi_val = hi;
    assign lo_val = lo;
`else
    assign md_busy = 1'b0;
    assign hi_val  = '0;
    assign lo_val  = '0;
`endif

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: ALU vector table, flush, mul/div sequences and randomized ALU traffic.
module tb_execute;
    localparam logic [31:0] DIV0 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_d, mem_to_reg_d, mem_write_d, branch_d, alu_src_d, reg_dst_d;
    logic [3:0]  alu_ctrl_d;
    logic [2:0]  md_op_d;
    logic [1:0]  j_inst_d;
    logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d, jump_addr_d;
    logic [4:0]  rt_d, rd_d;
    logic        flush_e;
    logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e;
    logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
    logic [4:0]  write_reg_e;
    logic        zero_e;
    logic [1:0]  j_inst_e;
    logic        md_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    execute #(.DIV0_LO(DIV0)) dut (
        .clk(clk), .rst(rst),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
        .branch_d(branch_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
        .alu_ctrl_d(alu_ctrl_d), .md_op_d(md_op_d), .j_inst_d(j_inst_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d), .pc_plus4_d(pc_plus4_d),
        .jump_addr_d(jump_addr_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .alu_out_e(alu_out_e), .write_data_e(write_data_e),
        .pc_branch_e(pc_branch_e), .jump_addr_e(jump_addr_e), .write_reg_e(write_reg_e),
        .zero_e(zero_e), .j_inst_e(j_inst_e), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0; branch_d = 0; alu_src_d = 0; reg_dst_d = 0;
        alu_ctrl_d = 0; md_op_d = 0; j_inst_d = 0; rd1_d = 0; rd2_d = 0; sign_imm_d = 0;
        pc_plus4_d = 0; jump_addr_d = 0; rt_d = 0; rd_d = 0; flush_e = 0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        int sh;
        sh = int'(imm[10:6]);
        case (c)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a ^ b;
            4'h4: return ~(a | b);
            4'h5: return (a < b) ? 32'd1 : 32'd0;
            4'h6: return a - b;
            4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: return b << sh;
            4'h9: return b >> sh;
            4'hA: return $unsigned($signed(b) >>> sh);
            4'hB: return {imm[15:0], 16'h0};
            default: return 32'd0;
        endcase
    endfunction

    // Reference HI:LO from plain 64-bit / integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] u;
        int sa, sb;
        sa = a; sb = b;
        case (op)
            3'd1: begin p = longint'(sa) * longint'(sb); return p; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; return u; end
            3'd3: begin
                if (b == 0) return {a, DIV0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, DIV0};
                return {a % b, a / b};
            end
        endcase
    endfunction

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] rs, rt, imm, pc4;
        logic        alu_src, reg_dst, branch;
        logic [31:0] e_alu;
        logic        e_zero;
        logic [4:0]  e_wr;
        logic [31:0] e_pcb;
    } vec_t;

    function automatic vec_t mkv(input logic [3:0] c, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] imm, input logic [31:0] pc4, input logic asrc,
                                 input logic rdst, input logic br, input logic [31:0] ea,
                                 input logic ez, input logic [4:0] ew, input logic [31:0] ep);
        vec_t v;
        v.ctrl = c; v.rs = rs; v.rt = rt; v.imm = imm; v.pc4 = pc4; v.alu_src = asrc;
        v.reg_dst = rdst; v.branch = br; v.e_alu = ea; v.e_zero = ez; v.e_wr = ew; v.e_pcb = ep;
        return v;
    endfunction

`ifdef EXECUTE_MULDIV_EN
    task automatic run_md(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
        int  busy_cnt;
        bit  frozen;
        clr_in();
        md_op_d = op; rd1_d = a; rd2_d = b; reg_write_d = 1; mem_write_d = 1;
        tick();
        busy_cnt = 0;
        frozen = 1;
        while (md_busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (reg_write_e !== 1'b0 || mem_write_e !== 1'b0 || write_data_e !== b) frozen = 0;
            rd1_d = $urandom; rd2_d = $urandom; md_op_d = 3'd2; flush_e = 1;
            tick();
        end
        chk({nm, " busy_cycles"}, busy_cnt, 33);
        chk({nm, " idex_frozen"}, {31'd0, frozen}, 1);
        clr_in(); md_op_d = 3'd5;
        tick();
        chk({nm, " mfhi"}, alu_out_e, e_hi);
        md_op_d = 3'd6;
        tick();
        chk({nm, " mflo"}, alu_out_e, e_lo);
        m_hi = e_hi; m_lo = e_lo;
    endtask
`endif

    initial begin
        vec_t vt[10];
        logic [63:0] hl;
        logic [31:0] srcb, e_alu, e_pcb, e_ja;
        logic [4:0]  e_wr;
        logic [3:0]  e_ctl;
        logic [1:0]  e_j;
        logic [31:0] e_wd;
        logic        fl;
        int          pick;

        vt[0] = mkv(4'h2, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1, 0, 32'd12, 0, 5'd8, 32'd0);
        vt[1] = mkv(4'h6, 32'd9, 32'd9, 32'd3, 32'h100, 0, 0, 1, 32'd0, 1, 5'd4, 32'h10C);
        vt[2] = mkv(4'h7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 0, 32'd1, 0, 5'd4, 32'd0);
        vt[3] = mkv(4'h5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 0, 32'd0, 1, 5'd4, 32'd0);
        vt[4] = mkv(4'hA, 32'd0, 32'h8000_0000, 32'h100, 32'd0, 0, 1, 0, 32'hF800_0000, 0, 5'd8, 32'h400);
        vt[5] = mkv(4'h9, 32'd0, 32'h8000_0000, 32'h100, 32'd0, 0, 1, 0, 32'h0800_0000, 0, 5'd8, 32'h400);
        vt[6] = mkv(4'hB, 32'd0, 32'd0, 32'h1234, 32'd0, 1, 0, 0, 32'h1234_0000, 0, 5'd4, 32'h48D0);
        vt[7] = mkv(4'h4, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 32'hFFFF_FFFF, 0, 5'd4, 32'd0);
        vt[8] = mkv(4'hE, 32'd5, 32'd7, 32'd0, 32'd0, 0, 0, 0, 32'd0, 1, 5'd4, 32'd0);
        vt[9] = mkv(4'h2, 32'h10, 32'd0, 32'hFFFF_FFF0, 32'h200, 1, 0, 0, 32'd0, 1, 5'd4, 32'h1C0);

        // Reset must win over live decode inputs.
        clr_in();
        rst = 1; reg_write_d = 1; mem_write_d = 1; branch_d = 1; rd1_d = 5; rd2_d = 7;
        alu_ctrl_d = 2; pc_plus4_d = 32'h40; jump_addr_d = 32'h88; j_inst_d = 2'b10; rd_d = 3; reg_dst_d = 1;
        tick(); tick();
        chk("rst alu_out", alu_out_e, 0);
        chk("rst ctrls", {28'd0, reg_write_e, mem_to_reg_e, mem_write_e, branch_e}, 0);
        chk("rst write_data", write_data_e, 0);
        chk("rst pc_branch", pc_branch_e, 0);
        chk("rst jump", {jump_addr_e[29:0], j_inst_e}, 0);
        chk("rst write_reg", {27'd0, write_reg_e}, 0);
        chk("rst md_busy", {31'd0, md_busy}, 0);
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            clr_in();
            alu_ctrl_d = vt[i].ctrl; rd1_d = vt[i].rs; rd2_d = vt[i].rt; sign_imm_d = vt[i].imm;
            pc_plus4_d = vt[i].pc4; alu_src_d = vt[i].alu_src; reg_dst_d = vt[i].reg_dst;
            branch_d = vt[i].branch; rt_d = 5'd4; rd_d = 5'd8;
            tick();
            chk($sformatf("vec%0d alu", i), alu_out_e, vt[i].e_alu);
            chk($sformatf("vec%0d zero", i), {31'd0, zero_e}, {31'd0, vt[i].e_zero});
            chk($sformatf("vec%0d wreg", i), {27'd0, write_reg_e}, {27'd0, vt[i].e_wr});
            chk($sformatf("vec%0d pcb", i), pc_branch_e, vt[i].e_pcb);
            chk($sformatf("vec%0d branch", i), {31'd0, branch_e}, {31'd0, vt[i].branch});
            chk($sformatf("vec%0d wdata", i), write_data_e, vt[i].rt);
        end

        // SW in decode while a flush bubbles ID/EX.
        clr_in();
        mem_write_d = 1; reg_write_d = 1; alu_src_d = 1; alu_ctrl_d = 2; rd1_d = 32'h100; sign_imm_d = 8;
        flush_e = 1;
        tick();
        chk("flush mem_write", {31'd0, mem_write_e}, 0);
        chk("flush reg_write", {31'd0, reg_write_e}, 0);
        chk("flush alu", alu_out_e, 0);
        flush_e = 0;
        tick();
        chk("sw mem_write", {31'd0, mem_write_e}, 1);
        chk("sw addr", alu_out_e, 32'h108);

`ifdef EXECUTE_MULDIV_EN
        run_md("mult", 3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 3'd4, 32'd10, 32'd0, 32'd10, DIV0);
        run_md("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(1, 4));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 0) b = -b;
            hl = ref_md(op, a, b);
            run_md($sformatf("rmd%0d", i), op, a, b, hl[63:32], hl[31:0]);
        end
`else
        // Without the mul/div unit, MULT/DIV are plain ALU ops and HI/LO read as 0.
        clr_in();
        md_op_d = 3'd1; alu_ctrl_d = 2; rd1_d = 7; rd2_d = 32'hFFFF_FFFD; reg_write_d = 1;
        tick();
        chk("nomd busy", {31'd0, md_busy}, 0);
        chk("nomd reg_write", {31'd0, reg_write_e}, 1);
        chk("nomd alu", alu_out_e, 32'd4);
        md_op_d = 3'd3;
        tick();
        chk("nomd div busy", {31'd0, md_busy}, 0);
        md_op_d = 3'd5;
        tick();
        chk("nomd mfhi", alu_out_e, 0);
        md_op_d = 3'd6; alu_ctrl_d = 2;
        tick();
        chk("nomd mflo", alu_out_e, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            clr_in();
            alu_ctrl_d = 4'($urandom_range(0, 15));
            rd1_d = $urandom; rd2_d = $urandom; sign_imm_d = $urandom;
            pc_plus4_d = $urandom; jump_addr_d = $urandom; j_inst_d = 2'($urandom);
            alu_src_d = 1'($urandom); reg_dst_d = 1'($urandom);
            reg_write_d = 1'($urandom); mem_to_reg_d = 1'($urandom);
            mem_write_d = 1'($urandom); branch_d = 1'($urandom);
            rt_d = 5'($urandom); rd_d = 5'($urandom);
`ifdef EXECUTE_MULDIV_EN
            pick = $urandom_range(0, 4);
            md_op_d = (pick == 3) ? 3'd5 : (pick == 4) ? 3'd6 : 3'd0;
`else
            pick = 0;
            md_op_d = 3'($urandom_range(0, 6));
`endif
            fl = ($urandom_range(0, 7) == 0);
            flush_e = fl;
            if (fl) begin
                e_alu = 0; e_pcb = 0; e_ja = 0; e_wr = 0; e_ctl = 0; e_j = 0; e_wd = 0;
            end else begin
                srcb = alu_src_d ? sign_imm_d : rd2_d;
                if (md_op_d == 3'd5)      e_alu = m_hi;
                else if (md_op_d == 3'd6) e_alu = m_lo;
                else                      e_alu = ref_alu(alu_ctrl_d, rd1_d, srcb, sign_imm_d);
                e_pcb = pc_plus4_d + sign_imm_d * 4;
                e_ja  = jump_addr_d;
                e_wr  = reg_dst_d ? rd_d : rt_d;
                e_ctl = {reg_write_d, mem_to_reg_d, mem_write_d, branch_d};
                e_j   = j_inst_d;
                e_wd  = rd2_d;
            end
            tick();
            chk($sformatf("rnd%0d alu", i), alu_out_e, e_alu);
            chk($sformatf("rnd%0d zero", i), {31'd0, zero_e}, {31'd0, e_alu == 0});
            chk($sformatf("rnd%0d pcb", i), pc_branch_e, e_pcb);
            chk($sformatf("rnd%0d wreg", i), {27'd0, write_reg_e}, {27'd0, e_wr});
            chk($sformatf("rnd%0d ctl", i), {28'd0, reg_write_e, mem_to_reg_e, mem_write_e, branch_e}, {28'd0, e_ctl});
            chk($sformatf("rnd%0d jump", i), jump_addr_e ^ {30'd0, j_inst_e}, e_ja ^ {30'd0, e_j});
            chk($sformatf("rnd%0d wdata", i), write_data_e, e_wd);
            chk($sformatf("rnd%0d busy", i), {31'd0, md_busy}, 0);
        end

`ifdef EXECUTE_MULDIV_EN
        // Reset landing at RUN cnt=10 clears HI/LO and drops md_busy.
        clr_in();
        md_op_d = 3'd1; rd1_d = 32'h12345; rd2_d = 32'h777; reg_write_d = 1;
        tick();
        clr_in();
        for (int i = 0; i < 11; i++) tick();
        chk("rstrun busy_before", {31'd0, md_busy}, 1);
        rst = 1;
        tick();
        chk("rstrun busy", {31'd0, md_busy}, 0);
        chk("rstrun alu", alu_out_e, 0);
        chk("rstrun wdata", write_data_e, 0);
        chk("rstrun ctrls", {28'd0, reg_write_e, mem_to_reg_e, mem_write_e, branch_e}, 0);
        rst = 0;
        md_op_d = 3'd6;
        tick();
        chk("rstrun mflo", alu_out_e, 0);
        md_op_d = 3'd5;
        tick();
        chk("rstrun mfhi", alu_out_e, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
